pe_mac_stream: RTL and testbench

- Parametrised successor to the counter-terminated systolic processing element: one multiply-accumulate cell of the systolic matrix-multiply array.
- Adds a valid-qualified data stream, a signed/unsigned mode and a synchronous accumulator clear.
- Adds back-to-back dot products with no bubble, and saturation to a reduced output width.
- Forwards operands right (a) and down (b) to neighbouring cells with one-cycle latency.

---
 rtl/pe_mac_stream.sv | 123 ++++++++++++
 tb/tb_pe_mac_stream.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_stream.sv
// Systolic multiply-accumulate cell with a valid-qualified operand stream.
// Sums DIMENSION valid beats of a*b and publishes each dot product,
// optionally saturated to O_BITS. Operands and valid are forwarded
// right/down with one cycle of latency.
module pe_mac_stream #(
  parameter int DIMENSION = 4,
  parameter int I_BITS    = 8,
  parameter int O_BITS    = 2*I_BITS+$clog2(DIMENSION),
  parameter int SIGNED    = 0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_clear,
  input  logic [I_BITS-1:0] i_a,
  input  logic [I_BITS-1:0] i_b,
  output logic [I_BITS-1:0] o_a,
  output logic [I_BITS-1:0] o_b,
  output logic              o_valid,
  output logic [O_BITS-1:0] o_c,
  output logic              o_c_valid,
  output logic              o_sat,
  output logic              o_busy
);

  localparam int LOG_D    = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam int P_BITS   = 2*I_BITS;
  localparam int ACC_BITS = P_BITS + LOG_D;
  localparam logic [LOG_D-1:0] LAST = LOG_D'(DIMENSION-1);

  logic [ACC_BITS-1:0] acc, prod, base, sum;
  logic [LOG_D-1:0]    count;
  logic [O_BITS-1:0]   c_sat;
  logic                final_beat, ovf;

  // Product extended to accumulator width by operand signedness.
  generate
    if (SIGNED != 0) begin : g_sprod
      logic signed [P_BITS-1:0] p;
      assign p    = $signed(i_a) * $signed(i_b);
      assign prod = {{LOG_D{p[P_BITS-1]}}, p};
    end else begin : g_uprod
      logic [P_BITS-1:0] p;
      assign p    = i_a * i_b;
      assign prod = {{LOG_D{1'b0}}, p};
    end
  endgenerate

  // A clear with a beat discards the old partial sum, so add onto zero.
  assign base = i_clear ? '0 : acc;
  assign sum  = base + prod;

  // After a clear the beat is beat 0, which is final only for DIMENSION=1.
  assign final_beat = i_valid && (i_clear ? (DIMENSION == 1) : (count == LAST));

  // Clip the full-width sum into O_BITS and flag when clipping occurred.
  generate
    if (O_BITS == ACC_BITS) begin : g_nosat
      assign c_sat = sum;
      assign ovf   = 1'b0;
    end else if (SIGNED != 0) begin : g_ssat
      localparam logic [O_BITS-1:0] SMIN = O_BITS'(1) << (O_BITS-1);
      localparam logic [O_BITS-1:0] SMAX = ~SMIN;
      logic [ACC_BITS-O_BITS:0] upper;
      assign upper = sum[ACC_BITS-1:O_BITS-1];
      assign ovf   = !((&upper) || (~|upper));
      assign c_sat = ovf ? (sum[ACC_BITS-1] ? SMIN : SMAX) : sum[O_BITS-1:0];
    end else begin : g_usat
      assign ovf   = |sum[ACC_BITS-1:O_BITS];
      assign c_sat = ovf ? '1 : sum[O_BITS-1:0];
    end
  endgenerate

  // Forward operands and valid to neighbours unconditionally.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_a     <= '0;
      o_b     <= '0;
      o_valid <= 1'b0;
    end else begin
      o_a     <= i_a;
      o_b     <= i_b;
      o_valid <= i_valid;
    end
  end

  // Accumulator and beat counter; idle cycles hold unless cleared.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      acc   <= '0;
      count <= '0;
    end else if (i_valid) begin
      if (final_beat) begin
        acc   <= '0;
        count <= '0;
      end else begin
        acc   <= sum;
        count <= i_clear ? LOG_D'(1) : count + 1'b1;
      end
    end else if (i_clear) begin
      acc   <= '0;
      count <= '0;
    end
  end

  // Publish the result for one pulse; o_c/o_sat hold until the next one.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_c       <= '0;
      o_sat     <= 1'b0;
      o_c_valid <= 1'b0;
    end else begin
      o_c_valid <= final_beat;
      if (final_beat) begin
        o_c   <= c_sat;
        o_sat <= ovf;
      end
    end
  end

  assign o_busy = (count != '0);

endmodule

// File: tb/tb_pe_mac_stream.sv
// Directed bench for pe_mac_stream: four configurations share one stimulus
// bus; each scenario task checks the instance(s) it concerns.
module tb_pe_mac_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid, clear;
  logic [7:0] ia, ib;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // u0: defaults (unsigned, O_BITS=18)
  logic [7:0] a0, b0; logic v0, cv0, s0, bz0; logic [17:0] c0;
  pe_mac_stream u0 (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_clear(clear),
    .i_a(ia), .i_b(ib), .o_a(a0), .o_b(b0), .o_valid(v0),
    .o_c(c0), .o_c_valid(cv0), .o_sat(s0), .o_busy(bz0));

  // u1: signed, O_BITS=18
  logic [7:0] a1, b1; logic v1, cv1, s1, bz1; logic [17:0] c1;
  pe_mac_stream #(.SIGNED(1)) u1 (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_clear(clear),
    .i_a(ia), .i_b(ib), .o_a(a1), .o_b(b1), .o_valid(v1),
    .o_c(c1), .o_c_valid(cv1), .o_sat(s1), .o_busy(bz1));

  // u2: unsigned, saturating to 16 bits
  logic [7:0] a2, b2; logic v2, cv2, s2, bz2; logic [15:0] c2;
  pe_mac_stream #(.O_BITS(16)) u2 (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_clear(clear),
    .i_a(ia), .i_b(ib), .o_a(a2), .o_b(b2), .o_valid(v2),
    .o_c(c2), .o_c_valid(cv2), .o_sat(s2), .o_busy(bz2));

  // u3: DIMENSION=1, signed, saturating to 8 bits
  logic [7:0] a3, b3; logic v3, cv3, s3, bz3; logic [7:0] c3;
  pe_mac_stream #(.DIMENSION(1), .SIGNED(1), .O_BITS(8)) u3 (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_clear(clear),
    .i_a(ia), .i_b(ib), .o_a(a3), .o_b(b3), .o_valid(v3),
    .o_c(c3), .o_c_valid(cv3), .o_sat(s3), .o_busy(bz3));

  // Apply one cycle of inputs; returns at the following negedge.
  task automatic drive(input logic v, input logic c, input logic [7:0] a, input logic [7:0] b);
    valid = v; clear = c; ia = a; ib = b;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid = 1'b0; clear = 1'b0; ia = 8'h5A; ib = 8'hA5;
    @(negedge clk);
    n_checks++;
    if ({a0, b0, v0, c0, cv0, s0, bz0} !== '0) begin
      n_fail++; $display("FAIL reset_u0 got %h required 0", {a0, b0, v0, c0, cv0, s0, bz0});
    end
    n_checks++;
    if ({c2, s2, cv2, bz2, c3, s3, cv3} !== '0) begin
      n_fail++; $display("FAIL reset_u2u3 got %h required 0", {c2, s2, cv2, bz2, c3, s3, cv3});
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_basic;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 8'(i), 8'(i));
      n_checks++;
      if (a0 !== 8'(i) || b0 !== 8'(i) || v0 !== 1'b1) begin
        n_fail++; $display("FAIL fwd_beat%0d got a=%0d b=%0d v=%0b required %0d", i, a0, b0, v0, i);
      end
      if (i < 4) begin
        n_checks++;
        if (cv0 !== 1'b0 || bz0 !== 1'b1) begin
          n_fail++; $display("FAIL early_beat%0d got cv=%0b busy=%0b required 0/1", i, cv0, bz0);
        end
      end
    end
    n_checks++;
    if (cv0 !== 1'b1 || c0 !== 18'd30 || s0 !== 1'b0 || bz0 !== 1'b0) begin
      n_fail++; $display("FAIL basic_result got cv=%0b c=%0d sat=%0b busy=%0b required 1/30/0/0", cv0, c0, s0, bz0);
    end
    drive(1'b0, 1'b0, 8'h33, 8'h44);
    n_checks++;
    if (cv0 !== 1'b0 || c0 !== 18'd30 || v0 !== 1'b0 || a0 !== 8'h33 || b0 !== 8'h44) begin
      n_fail++; $display("FAIL basic_hold got cv=%0b c=%0d v=%0b a=%h b=%h required 0/30/0/33/44", cv0, c0, v0, a0, b0);
    end
  endtask

  task automatic test_signed;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'hFF, 8'h02);
    n_checks++;
    if (cv1 !== 1'b1 || c1 !== 18'h3FFF8 || s1 !== 1'b0) begin
      n_fail++; $display("FAIL signed_neg got cv=%0b c=%h sat=%0b required 1/3fff8/0", cv1, c1, s1);
    end
    n_checks++;
    if (cv0 !== 1'b1 || c0 !== 18'd2040) begin
      n_fail++; $display("FAIL unsigned_ff got cv=%0b c=%0d required 1/2040", cv0, c0);
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_gaps;
    drive(1'b1, 1'b0, 8'd1, 8'd1);
    n_checks++;
    if (bz0 !== 1'b1) begin n_fail++; $display("FAIL gap_busy_first got %0b required 1", bz0); end
    drive(1'b0, 1'b0, 8'd7, 8'd7);
    drive(1'b0, 1'b0, 8'd7, 8'd7);
    n_checks++;
    if (bz0 !== 1'b1 || cv0 !== 1'b0) begin
      n_fail++; $display("FAIL gap_idle got busy=%0b cv=%0b required 1/0", bz0, cv0);
    end
    drive(1'b1, 1'b0, 8'd2, 8'd2);
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 8'd3, 8'd3);
    n_checks++;
    if (bz0 !== 1'b1 || cv0 !== 1'b0) begin
      n_fail++; $display("FAIL gap_third got busy=%0b cv=%0b required 1/0", bz0, cv0);
    end
    drive(1'b1, 1'b0, 8'd4, 8'd4);
    n_checks++;
    if (cv0 !== 1'b1 || c0 !== 18'd30 || bz0 !== 1'b0) begin
      n_fail++; $display("FAIL gap_result got cv=%0b c=%0d busy=%0b required 1/30/0", cv0, c0, bz0);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 1'b0, 8'd9, 8'd9);  // seed a different old result
    drive(1'b1, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 8'd1, 8'd1);
      n_checks++;
      if (i == 4 || i == 8) begin
        if (cv0 !== 1'b1 || c0 !== 18'd4) begin
          n_fail++; $display("FAIL b2b_pulse%0d got cv=%0b c=%0d required 1/4", i, cv0, c0);
        end
      end else if (cv0 !== 1'b0) begin
        n_fail++; $display("FAIL b2b_nopulse%0d got cv=%0b required 0", i, cv0);
      end
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_clear;
    drive(1'b1, 1'b0, 8'd9, 8'd9);
    drive(1'b1, 1'b0, 8'd9, 8'd9);
    drive(1'b1, 1'b1, 8'd5, 8'd5);
    n_checks++;
    if (bz0 !== 1'b1 || cv0 !== 1'b0) begin
      n_fail++; $display("FAIL clear_valid_busy got busy=%0b cv=%0b required 1/0", bz0, cv0);
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'd1, 8'd1);
    n_checks++;
    if (cv0 !== 1'b1 || c0 !== 18'd28) begin
      n_fail++; $display("FAIL clear_valid_result got cv=%0b c=%0d required 1/28", cv0, c0);
    end
    // Clear on an idle cycle: drop the partial sum, keep the old result.
    drive(1'b1, 1'b0, 8'd2, 8'd2);
    drive(1'b1, 1'b0, 8'd2, 8'd2);
    drive(1'b0, 1'b1, 8'd0, 8'd0);
    n_checks++;
    if (bz0 !== 1'b0 || cv0 !== 1'b0 || c0 !== 18'd28) begin
      n_fail++; $display("FAIL clear_idle got busy=%0b cv=%0b c=%0d required 0/0/28", bz0, cv0, c0);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'd1, 8'd1);
    n_checks++;
    if (cv0 !== 1'b1 || c0 !== 18'd4) begin
      n_fail++; $display("FAIL clear_idle_next got cv=%0b c=%0d required 1/4", cv0, c0);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_saturate_and_reset;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'd255, 8'd255);
    n_checks++;
    if (cv2 !== 1'b1 || c2 !== 16'hFFFF || s2 !== 1'b1) begin
      n_fail++; $display("FAIL sat16 got cv=%0b c=%h sat=%0b required 1/ffff/1", cv2, c2, s2);
    end
    n_checks++;
    if (c0 !== 18'd260100 || s0 !== 1'b0) begin
      n_fail++; $display("FAIL nosat18 got c=%0d sat=%0b required 260100/0", c0, s0);
    end
    drive(1'b1, 1'b0, 8'd255, 8'd255);
    drive(1'b1, 1'b0, 8'd255, 8'd255);
    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a2, b2, v2, c2, cv2, s2, bz2} !== '0 || c0 !== 18'd0 || bz0 !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got u2=%h c0=%0d busy0=%0b required 0", {a2, b2, v2, c2, cv2, s2, bz2}, c0, bz0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'd1, 8'd1);
    n_checks++;
    if (cv2 !== 1'b1 || c2 !== 16'd4 || s2 !== 1'b0) begin
      n_fail++; $display("FAIL after_reset got cv=%0b c=%0d sat=%0b required 1/4/0", cv2, c2, s2);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_dim1;
    drive(1'b1, 1'b0, 8'd3, 8'd3);
    n_checks++;
    if (cv3 !== 1'b1 || c3 !== 8'h09 || s3 !== 1'b0 || bz3 !== 1'b0) begin
      n_fail++; $display("FAIL d1_small got cv=%0b c=%h sat=%0b busy=%0b required 1/09/0/0", cv3, c3, s3, bz3);
    end
    drive(1'b1, 1'b0, 8'h80, 8'h80);
    n_checks++;
    if (cv3 !== 1'b1 || c3 !== 8'h7F || s3 !== 1'b1) begin
      n_fail++; $display("FAIL d1_satpos got cv=%0b c=%h sat=%0b required 1/7f/1", cv3, c3, s3);
    end
    drive(1'b1, 1'b0, 8'h80, 8'h7F);
    n_checks++;
    if (cv3 !== 1'b1 || c3 !== 8'h80 || s3 !== 1'b1) begin
      n_fail++; $display("FAIL d1_satneg got cv=%0b c=%h sat=%0b required 1/80/1", cv3, c3, s3);
    end
    drive(1'b1, 1'b0, 8'hFF, 8'h02);
    n_checks++;
    if (cv3 !== 1'b1 || c3 !== 8'hFE || s3 !== 1'b0) begin
      n_fail++; $display("FAIL d1_neg got cv=%0b c=%h sat=%0b required 1/fe/0", cv3, c3, s3);
    end
    drive(1'b0, 1'b0, 8'h11, 8'h11);
    n_checks++;
    if (cv3 !== 1'b0 || c3 !== 8'hFE) begin
      n_fail++; $display("FAIL d1_idle got cv=%0b c=%h required 0/fe", cv3, c3);
    end
    drive(1'b1, 1'b1, 8'd5, 8'd5);
    n_checks++;
    if (cv3 !== 1'b1 || c3 !== 8'h19) begin
      n_fail++; $display("FAIL d1_clear_beat got cv=%0b c=%h required 1/19", cv3, c3);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; clear = 1'b0; ia = '0; ib = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_signed();
    test_gaps();
    test_back_to_back();
    test_clear();
    test_saturate_and_reset();
    test_dim1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
